regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: consecutive lost cycles after which the ALU requester is forced to win.
REQ-002 SHALL have parameter DATA_W, default 32: write-back data width.
REQ-003 SHALL have port Clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports AluValid/AluRd/AluData  input  1/5/DATA_W  ALU write-back request.
REQ-006 SHALL have port AluReady  output  1  ALU request accepted this cycle.
REQ-007 SHALL have ports MemValid/MemRd/MemData  input  1/5/DATA_W  load write-back request.
REQ-008 SHALL have port MemReady  output  1  load request accepted this cycle.
REQ-009 SHALL have ports Write/WrReg/WrData  output  1/5/DATA_W  drive register-file write port (Write, reg3, r3In).
REQ-010 SHALL have ports ClaimValid/ClaimRd  input  1/5  decode reserves destination register.
REQ-011 SHALL have ports Rs/Rt  input  5/5  decode source registers.
REQ-012 SHALL have ports RsHazard/RtHazard  output  1/1  source has pending write.

Function
REQ-013 SHALL accept at most one request per cycle; Ready = Valid and granted, combinational.
REQ-014 SHALL grant Mem over Alu, except grant Alu when starve counter equals STARVE_MAX.
REQ-015 SHALL increment starve counter (saturating at STARVE_MAX) each cycle AluValid is high and not granted; clear it on Alu grant or AluValid low.
REQ-016 SHALL register accepted request: Write/WrReg/WrData valid the cycle after handshake (latency 1), stable through falling edge for register-file capture.
REQ-017 SHALL drive Write low in any cycle following no handshake.
REQ-018 SHALL complete handshake for Rd=0 but keep Write low (register 0 never written).
REQ-019 SHALL hold 32-bit pending vector: ClaimValid sets bit ClaimRd (ignored for 0); issued Write clears bit WrReg.
REQ-020 SHALL give set priority when claim and clear target same register in one cycle.
REQ-021 SHALL drive RsHazard=pending[Rs], RtHazard=pending[Rt], combinational; register 0 never hazardous.
REQ-022 SHALL flag protocol error (simulation assertion) if Valid drops or payload changes before Ready.

Reset
REQ-023 SHALL, on Reset_n low, asynchronously clear Write, WrReg, WrData, pending vector, starve counter.
REQ-024 SHALL hold AluReady, MemReady, hazards at 0 while Reset_n low; in-flight requests dropped, requesters re-present.
REQ-025 SHALL resume arbitration on first rising edge after Reset_n deasserts.

Configuration
REQ-026 With REGFILE_WB_BYPASS_EN defined SHALL add outputs RsFwd/RtFwd (1 bit) high when Write high and WrReg equals Rs/Rt (nonzero), and mask corresponding hazard unless re-claimed that cycle.
REQ-027 Without REGFILE_WB_BYPASS_EN SHALL omit RsFwd/RtFwd; hazards follow REQ-021 exactly.

Structure
REQ-028 SHALL place REG_ADDR_W=5, DATA_W default, wb_req_t (valid, rd, data) in package regfile_pkg.
REQ-029 SHALL implement pending vector and hazard lookup as sub-module regfile_scoreboard.

Verification
REQ-030 Alu only: AluRd=5, AluData=0x1234 -> AluReady same cycle; next cycle Write=1, WrReg=5, WrData=0x1234.
REQ-031 Both valid continuously, STARVE_MAX=3 -> Mem granted 3 cycles, Alu granted 4th, counter cleared.
REQ-032 Claim reg 8, then Rs=8 -> RsHazard=1 until cycle Write issued for reg 8, then 0.
REQ-033 MemRd=0 MemData=0xFFFF -> MemReady=1, Write stays 0, no pending change.
REQ-034 Claim reg 9 same cycle as Write to reg 9 -> pending[9] remains 1.
REQ-035 Reset_n low mid-stream with pending bits set -> Write=0, all hazards 0 immediately; after release, first request issues with latency 1.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared register-file write-back types and constants.
// Rev    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Pending-write vector with source-register hazard lookup.
//          REGFILE_WB_BYPASS_EN adds forwarding flags that mask hazards.
// Rev    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [REG_ADDR_W-1:0] wr_reg,
  input  logic                  claim_valid,
  input  logic [REG_ADDR_W-1:0] claim_rd,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  output logic                  rs_hazard,
  output logic                  rt_hazard
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                  rs_fwd,
  output logic                  rt_fwd
`endif
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // Claim is applied after the clear so a same-cycle claim wins.
  always_comb begin
    pending_nxt = pending;
    if (write) begin
      pending_nxt[wr_reg] = 1'b0;
    end
    if (claim_valid && (claim_rd != '0)) begin
      pending_nxt[claim_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic rs_reclaim;
  logic rt_reclaim;

  always_comb begin
    rs_fwd     = write && (wr_reg == rs) && (rs != '0);
    rt_fwd     = write && (wr_reg == rt) && (rt != '0);
    rs_reclaim = claim_valid && (claim_rd == rs);
    rt_reclaim = claim_valid && (claim_rd == rt);
    rs_hazard  = pending[rs] && !(rs_fwd && !rs_reclaim);
    rt_hazard  = pending[rt] && !(rt_fwd && !rt_reclaim);
  end
`else
  assign rs_hazard = pending[rs];
  assign rt_hazard = pending[rt];
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Arbitrates ALU/load write-backs onto one register-file write port
//          with starvation guard; REGFILE_WB_BYPASS_EN adds RsFwd/RtFwd.
// Rev    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int DATA_W     = regfile_pkg::DATA_W
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  AluValid,
  input  logic [REG_ADDR_W-1:0] AluRd,
  input  logic [DATA_W-1:0]     AluData,
  output logic                  AluReady,
  input  logic                  MemValid,
  input  logic [REG_ADDR_W-1:0] MemRd,
  input  logic [DATA_W-1:0]     MemData,
  output logic                  MemReady,
  output logic                  Write,
  output logic [REG_ADDR_W-1:0] WrReg,
  output logic [DATA_W-1:0]     WrData,
  input  logic                  ClaimValid,
  input  logic [REG_ADDR_W-1:0] ClaimRd,
  input  logic [REG_ADDR_W-1:0] Rs,
  input  logic [REG_ADDR_W-1:0] Rt,
  output logic                  RsHazard,
  output logic                  RtHazard
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                  RsFwd,
  output logic                  RtFwd
`endif
);

  localparam int               CNT_W        = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]      starve_cnt;
  logic                  alu_forced;
  logic                  alu_grant;
  logic                  mem_grant;
  logic                  handshake;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0]     sel_data;

  // Loads win by default; a starved ALU request overrides once the limit hits.
  always_comb begin
    alu_forced = (starve_cnt == STARVE_LIMIT);
    alu_grant  = AluValid && (!MemValid || alu_forced);
    mem_grant  = MemValid && !alu_grant;
    handshake  = alu_grant || mem_grant;
    sel_rd     = alu_grant ? AluRd   : MemRd;
    sel_data   = alu_grant ? AluData : MemData;
  end

  assign AluReady = Reset_n && alu_grant;
  assign MemReady = Reset_n && mem_grant;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      starve_cnt <= '0;
    end else if (!AluValid || alu_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Register 0 is hardwired: its requests are accepted but never written.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Write  <= 1'b0;
      WrReg  <= '0;
      WrData <= '0;
    end else begin
      Write <= handshake && (sel_rd != '0);
      if (handshake) begin
        WrReg  <= sel_rd;
        WrData <= sel_data;
      end
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .write       (Write),
    .wr_reg      (WrReg),
    .claim_valid (ClaimValid),
    .claim_rd    (ClaimRd),
    .rs          (Rs),
    .rt          (Rt),
    .rs_hazard   (RsHazard),
    .rt_hazard   (RtHazard)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .rs_fwd      (RsFwd),
    .rt_fwd      (RtFwd)
`endif
  );

  // Requesters must hold valid and payload steady until accepted.
  a_alu_hold: assert property (@(posedge Clock) disable iff (!Reset_n)
    (AluValid && !AluReady) |=> (AluValid && $stable(AluRd) && $stable(AluData)));

  a_mem_hold: assert property (@(posedge Clock) disable iff (!Reset_n)
    (MemValid && !MemReady) |=> (MemValid && $stable(MemRd) && $stable(MemData)));

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Brief  : Directed scoreboard bench for regfile_wb_arbiter (STARVE_MAX=3).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                  Clock = 1'b0;
  logic                  Reset_n;
  logic                  AluValid;
  logic [REG_ADDR_W-1:0] AluRd;
  logic [DATA_W-1:0]     AluData;
  logic                  AluReady;
  logic                  MemValid;
  logic [REG_ADDR_W-1:0] MemRd;
  logic [DATA_W-1:0]     MemData;
  logic                  MemReady;
  logic                  Write;
  logic [REG_ADDR_W-1:0] WrReg;
  logic [DATA_W-1:0]     WrData;
  logic                  ClaimValid;
  logic [REG_ADDR_W-1:0] ClaimRd;
  logic [REG_ADDR_W-1:0] Rs;
  logic [REG_ADDR_W-1:0] Rt;
  logic                  RsHazard;
  logic                  RtHazard;
`ifdef REGFILE_WB_BYPASS_EN
  logic                  RsFwd;
  logic                  RtFwd;
`endif

  regfile_wb_arbiter #(.STARVE_MAX(3), .DATA_W(DATA_W)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .AluValid   (AluValid),
    .AluRd      (AluRd),
    .AluData    (AluData),
    .AluReady   (AluReady),
    .MemValid   (MemValid),
    .MemRd      (MemRd),
    .MemData    (MemData),
    .MemReady   (MemReady),
    .Write      (Write),
    .WrReg      (WrReg),
    .WrData     (WrData),
    .ClaimValid (ClaimValid),
    .ClaimRd    (ClaimRd),
    .Rs         (Rs),
    .Rt         (Rt),
    .RsHazard   (RsHazard),
    .RtHazard   (RtHazard)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .RsFwd      (RsFwd),
    .RtFwd      (RtFwd)
`endif
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  wb_req_t exp_q[$];
  int      exp_cyc_q[$];
  int      checks = 0;
  int      errors = 0;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [REG_ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
    wb_req_t e;
    e.valid = 1'b1;
    e.rd    = rd;
    e.data  = data;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 1);
  endtask

  // One request cycle: check grants, and queue the write each accepted request should cause.
  task automatic tick(input bit ea, input bit em, input string name);
    @(negedge Clock);
    chk(AluReady, ea, {name, "_alu_ready"});
    chk(MemReady, em, {name, "_mem_ready"});
    if (ea && AluRd != '0) push_wb(AluRd, AluData);
    if (em && MemRd != '0) push_wb(MemRd, MemData);
    @(posedge Clock);
    #1;
  endtask

  task automatic hz(input bit ers, input bit ert, input string name);
    @(negedge Clock);
    chk(RsHazard, ers, {name, "_rs_hazard"});
    chk(RtHazard, ert, {name, "_rt_hazard"});
    @(posedge Clock);
    #1;
  endtask

  task automatic write_low(input string name);
    @(negedge Clock);
    chk(Write, 0, name);
    @(posedge Clock);
    #1;
  endtask

  // Monitor: every register-file write must match the oldest expected one, on time.
  always @(negedge Clock) begin
    wb_req_t e;
    int      ec;
    if (Reset_n) begin
      if (Write) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: actual reg=%0d data=%0h required no write", WrReg, WrData);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk(WrReg, e.rd, "wb_reg");
          chk(WrData, e.data, "wb_data");
          chk(cyc, ec, "wb_cycle");
        end
      end else if (exp_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
        checks++;
        errors++;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        $display("FAIL missing_write: actual no write required reg=%0d data=%0h at cycle %0d", e.rd, e.data, ec);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n    = 1'b0;
    AluValid   = 1'b1;
    AluRd      = 5'd3;
    AluData    = 32'h33;
    MemValid   = 1'b0;
    MemRd      = '0;
    MemData    = '0;
    ClaimValid = 1'b0;
    ClaimRd    = '0;
    Rs         = 5'd1;
    Rt         = 5'd2;

    @(negedge Clock);
    chk(Write, 0, "rst_write");
    chk(WrReg, 0, "rst_wrreg");
    chk(WrData, 0, "rst_wrdata");
    chk(AluReady, 0, "rst_alu_ready");
    chk(RsHazard, 0, "rst_rs_hazard");
    AluValid = 1'b0;
    #1 Reset_n = 1'b1;
    @(posedge Clock);
    #1;

    // Lone ALU request
    AluValid = 1'b1; AluRd = 5'd5; AluData = 32'h1234;
    tick(1, 0, "alu_only");
    AluValid = 1'b0;
    tick(0, 0, "idle0");
    write_low("no_handshake_write");

    // Starvation: three load wins, then the ALU is forced through
    AluValid = 1'b1; AluRd = 5'd6; AluData = 32'hA0;
    MemValid = 1'b1; MemRd = 5'd7; MemData = 32'hB0;
    tick(0, 1, "starve_c0");
    MemRd = 5'd11; MemData = 32'hB1;
    tick(0, 1, "starve_c1");
    MemRd = 5'd14; MemData = 32'hB2;
    tick(0, 1, "starve_c2");
    MemRd = 5'd15; MemData = 32'hB3;
    tick(1, 0, "starve_c3");
    AluRd = 5'd10; AluData = 32'hA1;
    tick(0, 1, "starve_c4");
    MemValid = 1'b0;
    tick(1, 0, "starve_c5");
    AluValid = 1'b0;
    tick(0, 0, "starve_idle");

    // Register 0 target: accepted, never written
    MemValid = 1'b1; MemRd = 5'd0; MemData = 32'hFFFF;
    tick(0, 1, "mem_rd0");
    MemValid = 1'b0;
    write_low("rd0_no_write");

    // Claim / hazard / release for register 8
    ClaimValid = 1'b1; ClaimRd = 5'd8; Rs = 5'd8; Rt = 5'd8;
    hz(0, 0, "claim8_same_cycle");
    ClaimValid = 1'b0;
    hz(1, 1, "claim8_pending");
    AluValid = 1'b1; AluRd = 5'd8; AluData = 32'h88;
    tick(1, 0, "wb8_req");
    AluValid = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    hz(0, 0, "wb8_cycle");
`else
    hz(1, 1, "wb8_cycle");
`endif
    hz(0, 0, "wb8_cleared");
    ClaimValid = 1'b1; ClaimRd = 5'd0; Rs = 5'd0; Rt = 5'd0;
    hz(0, 0, "claim0_cycle");
    ClaimValid = 1'b0;
    hz(0, 0, "reg0_never");

    // Claim and write-back of register 9 in the same cycle: claim wins
    AluValid = 1'b1; AluRd = 5'd9; AluData = 32'h99;
    tick(1, 0, "wb9_req");
    AluValid = 1'b0;
    ClaimValid = 1'b1; ClaimRd = 5'd9; Rs = 5'd9; Rt = 5'd0;
    hz(0, 0, "wb9_claim_cycle");
    ClaimValid = 1'b0;
    hz(1, 0, "set_priority");

    // Reset mid-stream with pending bits and a write in flight
    ClaimValid = 1'b1; ClaimRd = 5'd12;
    tick(0, 0, "claim12");
    ClaimValid = 1'b0; Rs = 5'd12; Rt = 5'd9;
    hz(1, 1, "pre_reset");
    AluValid = 1'b1; AluRd = 5'd13; AluData = 32'hD00D;
    tick(1, 0, "pre_reset_req");
    #1 Reset_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    chk(Write, 0, "mid_rst_write");
    chk(RsHazard, 0, "mid_rst_rs_hazard");
    chk(RtHazard, 0, "mid_rst_rt_hazard");
    chk(AluReady, 0, "mid_rst_alu_ready");
    @(negedge Clock);
    #1 Reset_n = 1'b1;
    #1;
    chk(AluReady, 1, "post_rst_alu_ready");
    push_wb(AluRd, AluData);
    @(posedge Clock);
    #1;
    AluValid = 1'b0;
    hz(0, 0, "post_rst_cleared");
    tick(0, 0, "tail");
    chk(exp_q.size(), 0, "queue_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
